bootrom_read_port: RTL

Bus-side read front end for the USB boot ROM macro. Accepts word-aligned single or burst read requests over a valid/ready channel, sequences the ROM's `me`/`oe`/`address` pins, absorbs the ROM's one-cycle registered read latency, and returns data beats over a valid/ready response channel with full backpressure. Sits directly upstream of `usbbootrom`, between it and the system interconnect.

---
 rtl/bootrom_pkg.sv | 26 ++
 rtl/bootrom_read_port_if.sv | 30 +++
 rtl/bootrom_rsp_fifo.sv | 50 +++++
 rtl/bootrom_read_port.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bootrom_pkg.sv
// Shared types and sizing for the USB boot ROM read front end.
// Word range test lives here so every user agrees on where the ROM ends.
package bootrom_pkg;

  localparam int BOOTROM_DEPTH  = 73728;
  localparam int BOOTROM_ADDR_W = 17;
  localparam int BOOTROM_DATA_W = 32;
  localparam int BOOTROM_LEN_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } bootrom_rd_state_e;

  typedef struct packed {
    logic [BOOTROM_DATA_W-1:0] data;
    logic                      err;
    logic                      last;
  } bootrom_beat_t;

  function automatic logic bootrom_word_ok(input logic [BOOTROM_ADDR_W:0] word,
                                           input logic                   mis);
    return !mis && (word < (BOOTROM_ADDR_W+1)'(BOOTROM_DEPTH));
  endfunction

endpackage

// File: rtl/bootrom_read_port_if.sv
// Request/response channels between the interconnect and the boot ROM read port.
interface bootrom_read_port_if
  import bootrom_pkg::*;
#(
  parameter int ADDR_W = BOOTROM_ADDR_W,
  parameter int DATA_W = BOOTROM_DATA_W,
  parameter int LEN_W  = BOOTROM_LEN_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W+1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              rsp_last;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_last
  );

endinterface

// File: rtl/bootrom_rsp_fifo.sv
// Two-entry response FIFO; the head entry drives the response channel directly.
module bootrom_rsp_fifo
  import bootrom_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  bootrom_beat_t push_beat,
  input  logic          pop,
  output bootrom_beat_t head,
  output logic          valid,
  output logic [1:0]    count
);

  bootrom_beat_t mem_r [2];
  logic [1:0]    count_r;
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign do_push_s = push && ((count_r != 2'd2) || pop);
  assign do_pop_s  = pop && (count_r != 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      count_r  <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_beat;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign valid = (count_r != 2'd0);
  assign count = count_r;

endmodule

// File: rtl/bootrom_read_port.sv
// Boot ROM read front end: turns word-aligned burst requests into ROM me/oe
// cycles and returns beats through a backpressured response FIFO.
module bootrom_read_port
  import bootrom_pkg::*;
#(
  parameter int ADDR_W = BOOTROM_ADDR_W,
  parameter int DATA_W = BOOTROM_DATA_W,
  parameter int DEPTH  = BOOTROM_DEPTH,
  parameter int LEN_W  = BOOTROM_LEN_W
) (
  input  logic                clock,
  input  logic                reset_n,
  bootrom_read_port_if.slave  bus,
  output logic                rom_me,
  output logic                rom_oe,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_q
);

  bootrom_rd_state_e state_r, state_s;
  logic [ADDR_W:0]   word_r, word_s;
  logic [LEN_W-1:0]  beats_left_r, beats_left_s;
  logic              mis_r, mis_s;
  logic              inflight_r, inflight_s;
  logic              err_slot_r, err_slot_s;
  logic              last_slot_r, last_slot_s;

  bootrom_beat_t     push_beat_s;
  bootrom_beat_t     head_s;
  logic              fifo_valid_s;
  logic [1:0]        fifo_count_s;
  logic              pop_s;
  logic [2:0]        occ_s;
  logic              credit_s;
  logic              beat_ok_s;

  // A beat leaving the FIFO this cycle frees its slot, keeping 1 beat/cycle.
  assign pop_s     = fifo_valid_s && bus.rsp_ready;
  assign occ_s     = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign credit_s  = (occ_s < 3'd2);
  assign beat_ok_s = bootrom_word_ok(word_r, mis_r);

  // Next-state, counters and ROM pin sequencing.
  always_comb begin
    state_s      = state_r;
    word_s       = word_r;
    beats_left_s = beats_left_r;
    mis_s        = mis_r;
    inflight_s   = 1'b0;
    err_slot_s   = 1'b0;
    last_slot_s  = 1'b0;
    rom_me       = 1'b0;
    rom_addr     = {ADDR_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          word_s       = {1'b0, bus.req_addr[ADDR_W+1:2]};
          beats_left_s = bus.req_len;
          mis_s        = |bus.req_addr[1:0];
          state_s      = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (credit_s) begin
          inflight_s  = 1'b1;
          err_slot_s  = !beat_ok_s;
          last_slot_s = (beats_left_r == {LEN_W{1'b0}});
          if (beat_ok_s) begin
            rom_me   = 1'b1;
            rom_addr = word_r[ADDR_W-1:0];
          end else begin
            rom_me = 1'b0;
          end
          word_s = word_r + (ADDR_W+1)'(1);
          if (beats_left_r == {LEN_W{1'b0}}) begin
            state_s = IDLE;
          end else begin
            beats_left_s = beats_left_r - LEN_W'(1);
          end
        end else begin
          state_s = BURST;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Burst control registers and the one-cycle ROM latency slot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      word_r       <= '0;
      beats_left_r <= '0;
      mis_r        <= 1'b0;
      inflight_r   <= 1'b0;
      err_slot_r   <= 1'b0;
      last_slot_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      word_r       <= word_s;
      beats_left_r <= beats_left_s;
      mis_r        <= mis_s;
      inflight_r   <= inflight_s;
      err_slot_r   <= err_slot_s;
      last_slot_r  <= last_slot_s;
    end
  end

  assign rom_oe = inflight_r && !err_slot_r;

  // Error beats carry zero data so a stale ROM output never leaks out.
  always_comb begin
    push_beat_s.data = err_slot_r ? '0 : rom_q;
    push_beat_s.err  = err_slot_r;
    push_beat_s.last = last_slot_r;
  end

  bootrom_rsp_fifo u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_r),
    .push_beat (push_beat_s),
    .pop       (pop_s),
    .head      (head_s),
    .valid     (fifo_valid_s),
    .count     (fifo_count_s)
  );

  assign bus.req_ready = (state_r == IDLE);
  assign bus.rsp_valid = fifo_valid_s;
  assign bus.rsp_data  = head_s.data;
  assign bus.rsp_err   = head_s.err;
  assign bus.rsp_last  = head_s.last;

endmodule
